// File: rtl/uart_mmio_periph.sv
// uart_mmio_periph
// Memory-mapped 8N1 UART on the CPU MEM-stage data bus.
//   TXD (BASE)   : write starts a frame when idle; reads return 0.
//   RXD (BASE+4) : read returns the last received byte and clears rx_ready.
//   CON (BASE+8) : [0]tx_ie [1]rx_ie [2]tx_done [3]rx_ready [4]tx_busy
//                  [5]frame_err [6]overrun. A write sets tx_ie/rx_ie from
//                  wdata[1:0]. A read clears tx_done/frame_err/overrun and
//                  returns the value they had before the clear.
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   rd, wr            bus read / write strobes
//   addr, wdata       byte address (full decode) and write data
//   rdata             combinational read data, 0 unless a mapped register is read
//   uart_rx, uart_tx  serial input (asynchronous) and registered serial output
//   irq               level interrupt: (tx_ie & tx_done) | (rx_ie & rx_ready)
module uart_mmio_periph #(
    parameter int          BAUD_DIV = 326,
    parameter logic [31:0] BASE     = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    localparam int          TW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [31:0] ADDR_TXD = BASE;
    localparam logic [31:0] ADDR_RXD = BASE + 32'd4;
    localparam logic [31:0] ADDR_CON = BASE + 32'd8;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

    // Oversample tick: free-running, shared by both directions.
    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TW'(BAUD_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else tick_cnt <= tick_cnt + TW'(1);
    end

    // Bus decode.
    logic txd_wr, con_wr, con_rd, rxd_rd;
    logic unused_wdata_bits;

    assign txd_wr = wr && (addr == ADDR_TXD);
    assign con_wr = wr && (addr == ADDR_CON);
    assign con_rd = rd && (addr == ADDR_CON);
    assign rxd_rd = rd && (addr == ADDR_RXD);
    assign unused_wdata_bits = ^wdata[31:8];

    logic       tx_ie, rx_ie, tx_done, rx_ready, frame_err, overrun;
    logic [7:0] rx_data;
    logic       tx_busy;

    always_comb begin
        rdata = '0;
        if (con_rd)
            rdata = {25'b0, overrun, frame_err, tx_busy, rx_ready, tx_done, rx_ie, tx_ie};
        else if (rxd_rd)
            rdata = {24'b0, rx_data};
    end

    assign irq = (tx_ie && tx_done) || (rx_ie && rx_ready);

    // RX synchroniser: p0 may go metastable, only p1 is used downstream.
    logic rx_sync_p0, rx_sync_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
        end else begin
            rx_sync_p0 <= uart_rx;
            rx_sync_p1 <= rx_sync_p0;
        end
    end

    // RX FSM.
    uart_state_t rx_state, rx_state_next;
    logic [3:0]  rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_cnt_clr, rx_sample, rx_stop_ok, rx_stop_err;

    always_comb begin
        rx_state_next = rx_state;
        rx_cnt_clr    = 1'b0;
        rx_sample     = 1'b0;
        rx_stop_ok    = 1'b0;
        rx_stop_err   = 1'b0;
        case (rx_state)
            ST_IDLE: begin
                if (!rx_sync_p1) begin
                    rx_state_next = ST_START;
                    rx_cnt_clr    = 1'b1;
                end
            end
            ST_START: begin
                // Half a bit in: a line already back high was a glitch.
                if (tick && rx_cnt == 4'd7) begin
                    rx_cnt_clr    = 1'b1;
                    rx_state_next = rx_sync_p1 ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick && rx_cnt == 4'd15) begin
                    rx_cnt_clr = 1'b1;
                    rx_sample  = 1'b1;
                    if (rx_bit == 3'd7) rx_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick && rx_cnt == 4'd15) begin
                    rx_cnt_clr    = 1'b1;
                    rx_state_next = ST_IDLE;
                    if (rx_sync_p1) rx_stop_ok  = 1'b1;
                    else            rx_stop_err = 1'b1;
                end
            end
            default: rx_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_next;
            if (rx_cnt_clr) rx_cnt <= '0;
            else if (tick)  rx_cnt <= rx_cnt + 4'd1;
            if (rx_state != ST_DATA) rx_bit <= '0;
            else if (rx_sample)      rx_bit <= rx_bit + 3'd1;
            // LSB arrives first, so shift in from the top.
            if (rx_sample) rx_shift <= {rx_sync_p1, rx_shift[7:1]};
        end
    end

    // TX FSM.
    uart_state_t tx_state, tx_state_next;
    logic [3:0]  tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift, tx_shift_next;
    logic        tx_cnt_clr, tx_shift_en, tx_finish, tx_line_next;

    assign tx_busy = (tx_state != ST_IDLE);

    always_comb begin
        tx_state_next = tx_state;
        tx_cnt_clr    = 1'b0;
        tx_shift_en   = 1'b0;
        tx_finish     = 1'b0;
        tx_shift_next = tx_shift;
        case (tx_state)
            ST_IDLE: begin
                if (txd_wr) begin
                    tx_state_next = ST_START;
                    tx_cnt_clr    = 1'b1;
                    tx_shift_next = wdata[7:0];
                end
            end
            ST_START: begin
                if (tick && tx_cnt == 4'd15) begin
                    tx_cnt_clr    = 1'b1;
                    tx_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick && tx_cnt == 4'd15) begin
                    tx_cnt_clr    = 1'b1;
                    tx_shift_en   = 1'b1;
                    tx_shift_next = {1'b0, tx_shift[7:1]};
                    if (tx_bit == 3'd7) tx_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick && tx_cnt == 4'd15) begin
                    tx_cnt_clr    = 1'b1;
                    tx_finish     = 1'b1;
                    tx_state_next = ST_IDLE;
                end
            end
            default: tx_state_next = ST_IDLE;
        endcase

        // Line level follows the state being entered, so uart_tx is a plain flop.
        case (tx_state_next)
            ST_START: tx_line_next = 1'b0;
            ST_DATA:  tx_line_next = tx_shift_next[0];
            default:  tx_line_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_next;
            tx_shift <= tx_shift_next;
            uart_tx  <= tx_line_next;
            if (tx_cnt_clr) tx_cnt <= '0;
            else if (tick)  tx_cnt <= tx_cnt + 4'd1;
            if (tx_state != ST_DATA) tx_bit <= '0;
            else if (tx_shift_en)    tx_bit <= tx_bit + 3'd1;
        end
    end

    // Flags and control registers; a set on the same edge as a clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_ie     <= 1'b0;
            rx_ie     <= 1'b0;
            tx_done   <= 1'b0;
            rx_ready  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            rx_data   <= '0;
        end else begin
            if (con_wr) begin
                tx_ie <= wdata[0];
                rx_ie <= wdata[1];
            end
            tx_done   <= tx_finish   || (tx_done   && !con_rd);
            frame_err <= rx_stop_err || (frame_err && !con_rd);
            overrun   <= (rx_stop_ok && rx_ready) || (overrun && !con_rd);
            rx_ready  <= rx_stop_ok  || (rx_ready  && !rxd_rd);
            if (rx_stop_ok) rx_data <= rx_shift;
        end
    end

endmodule

// File: tb/tb_uart_mmio_periph.sv
// tb_uart_mmio_periph
// Directed bench for uart_mmio_periph with BAUD_DIV=2 (one bit = 32 clk).
// Covers reset state, transmit framing, receive, overrun, glitch rejection,
// framing error and writes to TXD while a frame is in flight.
module tb_uart_mmio_periph;

    localparam logic [31:0] TXD = 32'h4000_0018;
    localparam logic [31:0] RXD = 32'h4000_001C;
    localparam logic [31:0] CON = 32'h4000_0020;

    logic        clk, reset, rd, wr;
    logic [31:0] addr, wdata, rdata;
    logic        uart_rx, uart_tx, irq;
    int          checks, errors;
    logic [9:0]  frame;
    int          lows;

    uart_mmio_periph #(.BAUD_DIV(2), .BASE(32'h4000_0018)) dut (
        .clk     (clk),
        .reset   (reset),
        .rd      (rd),
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        rd   = 1'b1;
        addr = a;
        #1 d = rdata;
        @(negedge clk);
        rd   = 1'b0;
        addr = '0;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        chk(tag, d, exp);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wr    = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
    endtask

    // Drives one 8N1 frame; stop_len lets a low stop bit be released early.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int stop_len);
        uart_rx = 1'b0;
        repeat (32) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (32) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (stop_len) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    // Waits for the start bit, then samples start, 8 data bits and stop mid-bit.
    task automatic capture_tx(input string tag, output logic [9:0] bits);
        int n;
        n = 0;
        while (uart_tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 200), 32'd1);
        repeat (16) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            bits[k] = uart_tx;
            repeat (32) @(negedge clk);
        end
    endtask

    task automatic count_tx_low(input int ncyc, output int cnt);
        cnt = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) cnt++;
        end
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; rd = 1'b0; wr = 1'b0;
        addr = '0; wdata = '0; uart_rx = 1'b1;
        checks = 0; errors = 0;

        // Power-on reset state.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_uart_tx", 32'(uart_tx), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_rdata_idle", rdata, 32'd0);
        reset = 1'b0;
        read_chk("rst_con", CON, 32'h00);
        read_chk("rst_rxd", RXD, 32'h00);
        read_chk("txd_read_zero", TXD, 32'h00);

        // Transmit 0xA5 with tx_ie set.
        bus_write(CON, 32'h1);
        bus_write(TXD, 32'hA5);
        read_chk("t2_busy", CON, 32'h11);
        capture_tx("t2_start_seen", frame);
        // Line order 0,1,0,1,0,0,1,0,1,1 written as bit9..bit0.
        chk("t2_frame", {22'b0, frame}, {22'b0, 10'b1101001010});
        chk("t2_irq_set", 32'(irq), 32'd1);
        read_chk("t2_con_done", CON, 32'h05);
        chk("t2_irq_clr", 32'(irq), 32'd0);
        read_chk("t2_con_after", CON, 32'h01);

        // Reset in the middle of a frame.
        bus_write(CON, 32'h3);
        bus_write(TXD, 32'h5A);
        repeat (5) @(negedge clk);
        chk("t1_tx_low_pre", 32'(uart_tx), 32'd0);
        read_chk("t1_busy", CON, 32'h13);
        #2 reset = 1'b1;
        #1;
        chk("t1_tx_async", 32'(uart_tx), 32'd1);
        chk("t1_irq", 32'(irq), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        read_chk("t1_con_after", CON, 32'h00);
        count_tx_low(60, lows);
        chk("t1_no_resume", 32'(lows), 32'd0);

        // Receive 0x3C with rx_ie set.
        bus_write(CON, 32'h2);
        send_rx(8'h3C, 1'b1, 32);
        chk("t3_irq_set", 32'(irq), 32'd1);
        read_chk("t3_con_ready", CON, 32'h0A);
        read_chk("t3_rxd", RXD, 32'h3C);
        read_chk("t3_con_after", CON, 32'h02);
        chk("t3_irq_clr", 32'(irq), 32'd0);

        // Overrun: two frames back to back without reading.
        send_rx(8'h11, 1'b1, 32);
        send_rx(8'h22, 1'b1, 32);
        read_chk("t4_con_ovr", CON, 32'h4A);
        read_chk("t4_rxd", RXD, 32'h22);
        read_chk("t4_con_after", CON, 32'h02);

        // Short low glitch must not start a reception.
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (100) @(negedge clk);
        read_chk("t5_glitch", CON, 32'h02);
        // Low stop bit, held past its sample point then released so the
        // receiver's re-arm sees a high line.
        send_rx(8'h55, 1'b0, 24);
        repeat (40) @(negedge clk);
        read_chk("t5_con_ferr", CON, 32'h22);
        read_chk("t5_rxd_kept", RXD, 32'h22);
        read_chk("t5_con_after", CON, 32'h02);
        chk("t5_irq", 32'(irq), 32'd0);

        // Second TXD write during a frame is dropped.
        bus_write(CON, 32'h1);
        bus_write(TXD, 32'h01);
        bus_write(TXD, 32'hFF);
        capture_tx("t6_start_seen", frame);
        // Line order 0,1,0,0,0,0,0,0,0,1 written as bit9..bit0.
        chk("t6_frame", {22'b0, frame}, {22'b0, 10'b1000000010});
        read_chk("t6_con_done", CON, 32'h05);
        count_tx_low(400, lows);
        chk("t6_no_second", 32'(lows), 32'd0);
        read_chk("t6_con_single", CON, 32'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
